// File: rtl/muldiv_unit.sv
// ============================================================================
// muldiv_unit : iterative MIPS mult/div unit that owns the HI/LO registers
// Revision    : 1.0
// ============================================================================
`default_nettype none

module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             writehi,
  input  logic             writelo,
  input  logic [WIDTH-1:0] hlwd,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FIX = 2'd2} state_t;

  state_t             state, state_next;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [CW-1:0]      count;
  logic               is_div, neg_res, neg_rem;

  logic               start_sign_a, start_sign_b, start_signed;
  logic [WIDTH-1:0]   start_a_mag, start_b_mag;

  assign start_signed = ~opE[0];
  assign start_sign_a = start_signed & srcaE[WIDTH-1];
  assign start_sign_b = start_signed & srcbE[WIDTH-1];
  assign start_a_mag  = start_sign_a ? (~srcaE + 1'b1) : srcaE;
  assign start_b_mag  = start_sign_b ? (~srcbE + 1'b1) : srcbE;

  // Multiply step: add the multiplicand into the upper half when the
  // multiplier LSB is set, then shift the whole accumulator right.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mcand} : '0);
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};

  // Restoring divide step: acc holds {remainder, dividend/quotient}.
  logic [2*WIDTH:0]   div_sh;
  logic [WIDTH:0]     div_trial;
  logic               div_q;
  logic [2*WIDTH-1:0] div_next;
  assign div_sh    = {acc, 1'b0};
  assign div_trial = div_sh[2*WIDTH:WIDTH] - {1'b0, mcand};
  assign div_q     = ~div_trial[WIDTH];
  assign div_next  = div_q ? {div_trial[WIDTH-1:0], div_sh[WIDTH-1:1], 1'b1}
                           : {div_sh[2*WIDTH-1:1], 1'b0};

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (startE) state_next = RUN;
      RUN:     if (count == CW'(1)) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      count   <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == FIX);
      case (state)
        IDLE: begin
          if (startE) begin
            is_div  <= opE[1];
            // A zero divisor leaves quotient all ones and remainder |a|;
            // re-signing the remainder then restores the raw dividend.
            neg_res <= (start_sign_a ^ start_sign_b) & ~(opE[1] & (srcbE == '0));
            neg_rem <= start_sign_a;
            count   <= CW'(WIDTH);
            acc     <= opE[1] ? {{WIDTH{1'b0}}, start_a_mag} : {{WIDTH{1'b0}}, start_b_mag};
            mcand   <= opE[1] ? start_b_mag : start_a_mag;
          end else begin
            if (writehi) hi <= hlwd;
            if (writelo) lo <= hlwd;
          end
        end
        RUN: begin
          count <= count - CW'(1);
          acc   <= is_div ? div_next : mul_next;
        end
        FIX: begin
          if (is_div) begin
            lo <= neg_res ? (~acc[WIDTH-1:0] + 1'b1) : acc[WIDTH-1:0];
            hi <= neg_rem ? (~acc[2*WIDTH-1:WIDTH] + 1'b1) : acc[2*WIDTH-1:WIDTH];
          end else begin
            {hi, lo} <= neg_res ? (~acc + 1'b1) : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multiply/divide unit in the execute stage of the pipelined MIPS core. It owns the architectural HI/LO registers. It executes mult/multu/div/divu when the decoder flags a mult-or-div op in E, and serves mfhi/mflo reads and mthi/mtlo writes. It raises busy so the hazard unit stalls any HI/LO access until the result has committed.

Parameters:
WIDTH, 32, operand width; HI/LO width; iteration count of each operation.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset (0 = reset)
startE  input  1  start an operation; qualified by multordivE from the decode pipeline
opE  input  2  operation select: 00 mult, 01 multu, 10 div, 11 divu
srcaE  input  WIDTH  rs operand (multiplicand / dividend)
srcbE  input  WIDTH  rt operand (multiplier / divisor)
writehi  input  1  mthi: load HI from hlwd
writelo  input  1  mtlo: load LO from hlwd
hlwd  input  WIDTH  mthi/mtlo write data
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register
busy  output  1  operation in flight; hazard unit stalls mfhi/mflo/mthi/mtlo/new start
done  output  1  one-cycle pulse, high in the commit cycle

Behaviour:
- Reset (reset=0, async): state=IDLE, hi=0, lo=0, busy=0, done=0, all datapath registers cleared. Reset mid-operation aborts the operation; HI/LO return to 0.
- FSM states: IDLE, RUN, FIX.
  - IDLE -> RUN on a clock edge with startE=1. The edge latches opE, signedness, result sign bits, |srcaE|, |srcbE| (magnitudes only for the signed ops) and loads the iteration counter with WIDTH.
  - RUN: one iteration per cycle; counter decrements. RUN -> FIX after exactly WIDTH RUN cycles.
  - FIX: single cycle. Applies sign correction and writes HI/LO at the closing edge. done=1 during FIX. FIX -> IDLE.
- busy = (state != IDLE), registered. It is high for WIDTH+1 cycles, starting the cycle after the start edge. New HI/LO values are visible in the first cycle busy=0.
- Multiply: radix-2 shift-add on a 2*WIDTH accumulator. HI = upper half, LO = lower half. For mult, negate the 2*WIDTH product if sign(a) XOR sign(b).
- Divide: restoring division on magnitudes. LO = quotient, HI = remainder.
  - div: negate the quotient if sign(a) XOR sign(b); the remainder takes the sign of the dividend.
  - div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- Divide by zero (srcbE=0, div or divu): LO=all ones, HI=dividend as given (raw srcaE). No sign correction. Same WIDTH+1 latency.
- startE while busy=1 is ignored; the hazard unit must prevent it.
- writehi/writelo: honoured only when state=IDLE and startE=0. HI/LO update at that edge. Both may be asserted together. Ignored while busy.
- startE together with writehi/writelo in IDLE: start wins; the write is dropped.
- The FIX commit overwrites HI and LO together; there are no partial updates.
- Outputs hi/lo are direct register outputs, with no combinational path from inputs.

Test Plan:
- Reset then mult 7 x -3 (0xFFFFFFFD): busy high for 33 cycles, done pulses once, then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- multu 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. Same operands with mult -> hi=0, lo=1.
- div -7 / 2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu 100 / 7 -> lo=14, hi=2. div 0x80000000 / -1 -> lo=0x80000000, hi=0.
- div 5 / 0 -> lo=0xFFFFFFFF, hi=5, after the normal 33-cycle busy window.
- mthi 0x1234 then mtlo 0x5678 in IDLE -> hi=0x1234, lo=0x5678 next cycle. writehi during busy -> ignored, and the op result commits.
- Start divu, assert reset=0 at RUN cycle 10 -> immediately state IDLE, busy=0, done=0, hi=lo=0. A second startE at RUN cycle 5 of a fresh op -> ignored, and the first op's result is correct.
